reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 139 +++++++++++++
 tb/tb_reg_file_sb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//   32-entry register file with a single-bit write scoreboard.
//   X0..X30 are real WIDTH-bit registers; index 31 reads as constant zero
//   and has no storage. Two combinational read ports with write-then-read
//   bypass, one writeback port, and an issue port that marks a destination
//   register as pending until its writeback arrives.
//
// Ports
//   clk       in   1      clock, all state updates on rising edge
//   reset_n   in   1      asynchronous active-low reset
//   rd_addr1  in   5      read port 1 index
//   rd_addr2  in   5      read port 2 index
//   rd_data1  out  WIDTH  read port 1 data (combinational, bypassed)
//   rd_data2  out  WIDTH  read port 2 data (combinational, bypassed)
//   wr_en     in   1      writeback strobe
//   wr_addr   in   5      writeback index
//   wr_data   in   WIDTH  writeback data
//   iss_en    in   1      issue strobe, marks iss_addr pending
//   iss_addr  in   5      issuing instruction destination index
//   busy1     out  1      rd_addr1 has an outstanding write
//   busy2     out  1      rd_addr2 has an outstanding write
// ---------------------------------------------------------------------------
module reg_file_sb #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rd_addr1,
  input  logic [4:0]       rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             iss_en,
  input  logic [4:0]       iss_addr,
  output logic             busy1,
  output logic             busy2
);

  localparam int         NREG     = 31;
  localparam int         NPORT    = 2;
  localparam logic [4:0] ZERO_IDX = 5'd31;

  // Storage and scoreboard state
  logic [WIDTH-1:0] x_reg [NREG];
  logic [NREG-1:0]  pend_reg;

  // Index 31 never touches state: qualify both strobes once here
  logic wr_valid;
  logic iss_valid;

  assign wr_valid  = wr_en  && (wr_addr  != ZERO_IDX);
  assign iss_valid = iss_en && (iss_addr != ZERO_IDX);

  // One-hot decode of write and issue targets
  logic [NREG-1:0] wr_sel;
  logic [NREG-1:0] iss_sel;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_decode
      assign wr_sel[gi]  = wr_valid  && (wr_addr  == 5'(gi));
      assign iss_sel[gi] = iss_valid && (iss_addr == 5'(gi));
    end
  endgenerate

  // Register storage: one flop bank per register so the asynchronous
  // clear reaches every entry independently of the clock.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          x_reg[gi] <= '0;
        end else if (wr_sel[gi]) begin
          x_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Scoreboard: clear on writeback, then OR in the issue mask so an issue
  // and a writeback to the same index on one edge leaves the bit set (the
  // newer instruction still owns the register). Re-issuing a pending index
  // simply re-sets an already-set bit.
  logic [NREG-1:0] pend_next;

  assign pend_next = (pend_reg & ~wr_sel) | iss_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  // 32-entry views used by the read muxes; entry 31 is hard zero.
  logic [WIDTH-1:0] rd_src [32];
  logic [31:0]      pend_full;

  assign pend_full = {1'b0, pend_reg};

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_src
      if (gi < NREG) begin : g_store
        assign rd_src[gi] = x_reg[gi];
      end else begin : g_zero
        assign rd_src[gi] = '0;
      end
    end
  endgenerate

  // Read ports. A matching writeback overrides the stored value and also
  // hides the pending bit, since the value is being delivered this cycle.
  // wr_valid already excludes index 31, so port reads of 31 stay zero.
  logic [4:0]       port_addr [NPORT];
  logic [WIDTH-1:0] port_data [NPORT];
  logic             port_busy [NPORT];

  assign port_addr[0] = rd_addr1;
  assign port_addr[1] = rd_addr2;

  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
      logic hit;

      assign hit           = wr_valid && (wr_addr == port_addr[gi]);
      assign port_data[gi] = hit ? wr_data : rd_src[port_addr[gi]];
      assign port_busy[gi] = pend_full[port_addr[gi]] && !hit;
    end
  endgenerate

  assign rd_data1 = port_data[0];
  assign rd_data2 = port_data[1];
  assign busy1    = port_busy[0];
  assign busy2    = port_busy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
//   Directed bench for reg_file_sb. A behavioural model (plain arrays of
//   register values and pending flags) tracks the architectural state; a
//   compare process checks both read ports and both busy flags against it
//   every cycle, and literal expectations pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

  localparam int W = 64;

  logic         clk;
  logic         reset_n;
  logic [4:0]   rd_addr1;
  logic [4:0]   rd_addr2;
  logic [W-1:0] rd_data1;
  logic [W-1:0] rd_data2;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic         iss_en;
  logic [4:0]   iss_addr;
  logic         busy1;
  logic         busy2;

  int checks   = 0;
  int failures = 0;
  bit check_en = 0;

  reg_file_sb #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy1    (busy1),
    .busy2    (busy2)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_x    [32] = '{default: '0};
  bit           m_pend [32] = '{default: 0};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        m_x[i]    <= '0;
        m_pend[i] <= 0;
      end
    end else begin
      if (wr_en && wr_addr != 5'd31) begin
        m_x[wr_addr]    <= wr_data;
        m_pend[wr_addr] <= 0;
      end
      if (iss_en && iss_addr != 5'd31) m_pend[iss_addr] <= 1;
    end
  end

  function automatic logic [W-1:0] exp_rd(input logic [4:0] a);
    if (a == 5'd31) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_x[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd31) return 1'b0;
    if (wr_en && wr_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Per-cycle compare, sampled between the input change and the next edge.
  always @(negedge clk) begin
    if (check_en) begin
      #2;
      chk("model_rd_data1", rd_data1, exp_rd(rd_addr1));
      chk("model_rd_data2", rd_data2, exp_rd(rd_addr2));
      chk("model_busy1", {63'd0, busy1}, {63'd0, exp_busy(rd_addr1)});
      chk("model_busy2", {63'd0, busy2}, {63'd0, exp_busy(rd_addr2)});
      $display("cyc t=%0t rst_n=%0b we=%0b wa=%0d ie=%0b ia=%0d a1=%0d d1=%h b1=%0b a2=%0d d2=%h b2=%0b",
               $time, reset_n, wr_en, wr_addr, iss_en, iss_addr,
               rd_addr1, rd_data1, busy1, rd_addr2, rd_data2, busy2);
    end
  end

  // Apply one cycle of inputs at the falling edge; returns 3 time units
  // later so literal checks run after the compare process and before the
  // next rising edge.
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [W-1:0] wd,
                     input logic ie, input logic [4:0] ia,
                     input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
    rd_addr1 = a1; rd_addr2 = a2;
    #3;
  endtask

  function automatic logic [W-1:0] fill_val(input int i);
    return {32'hC0DE_0000 | 32'(i), 32'(i * 3 + 1)};
  endfunction

  initial begin
    reset_n = 0;
    wr_en = 0; wr_addr = 0; wr_data = '0;
    iss_en = 0; iss_addr = 0;
    rd_addr1 = 5; rd_addr2 = 9;

    // Reset state
    #12;
    chk("reset_rd_data1", rd_data1, '0);
    chk("reset_busy1", {63'd0, busy1}, '0);
    @(negedge clk);
    reset_n = 1;
    check_en = 1;

    // Write X5, bypass then stored read
    cyc(1, 5, 64'h0123_4567_89AB_CDEF, 0, 0, 5, 31);
    chk("x5_bypass", rd_data1, 64'h0123_4567_89AB_CDEF);
    cyc(0, 0, '0, 0, 0, 5, 31);
    chk("x5_stored", rd_data1, 64'h0123_4567_89AB_CDEF);

    // Write to X31 is discarded; reads of 31 stay zero
    cyc(1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 5, 31);
    chk("x31_same_cycle", rd_data2, '0);
    cyc(0, 0, '0, 0, 0, 5, 31);
    chk("x31_after", rd_data2, '0);

    // Same-cycle bypass on X7
    cyc(1, 7, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0, 7, 5);
    chk("x7_bypass", rd_data1, 64'hAAAA_AAAA_AAAA_AAAA);
    cyc(0, 0, '0, 0, 0, 7, 5);
    chk("x7_stored", rd_data1, 64'hAAAA_AAAA_AAAA_AAAA);

    // Issue X3, busy until writeback
    cyc(0, 0, '0, 1, 3, 3, 31);
    chk("x3_busy_issue_cycle", {63'd0, busy1}, '0);
    cyc(0, 0, '0, 0, 0, 3, 31);
    chk("x3_busy", {63'd0, busy1}, 64'd1);
    cyc(1, 3, 64'h3333, 0, 0, 3, 31);
    chk("x3_wb_not_busy", {63'd0, busy1}, '0);
    cyc(0, 0, '0, 0, 0, 3, 31);
    chk("x3_cleared", {63'd0, busy1}, '0);

    // Simultaneous issue and writeback of X9: issue wins
    cyc(1, 9, 64'h9999, 1, 9, 31, 9);
    cyc(0, 0, '0, 0, 0, 31, 9);
    chk("x9_set_wins", {63'd0, busy2}, 64'd1);
    chk("x9_data", rd_data2, 64'h9999);

    // Issue to 31 never makes 31 busy
    cyc(0, 0, '0, 1, 31, 31, 9);
    chk("iss31_busy_same", {63'd0, busy1}, '0);
    cyc(0, 0, '0, 0, 0, 31, 9);
    chk("iss31_busy_after", {63'd0, busy1}, '0);

    // Independent set (10) and clear (9) on one edge
    cyc(1, 9, 64'h9A9A, 1, 10, 10, 9);
    cyc(0, 0, '0, 0, 0, 10, 9);
    chk("x10_set", {63'd0, busy1}, 64'd1);
    chk("x9_cleared", {63'd0, busy2}, '0);

    // Re-issue of pending X10 does not count: one writeback clears it
    cyc(0, 0, '0, 1, 10, 10, 9);
    cyc(1, 10, 64'h1010, 0, 0, 31, 9);
    cyc(0, 0, '0, 0, 0, 10, 9);
    chk("x10_single_bit", {63'd0, busy1}, '0);

    // Load all registers, sweep; then invert, sweep
    for (int i = 0; i < 31; i++) cyc(1, 5'(i), fill_val(i), 0, 0, 5'(i), 5'(30 - i));
    for (int i = 0; i < 32; i++) cyc(0, 0, '0, 0, 0, 5'(i), 5'(31 - i));
    cyc(0, 0, '0, 0, 0, 17, 0);
    chk("sweep_x17", rd_data1, 64'hC0DE_0011_0000_0034);
    for (int i = 0; i < 31; i++) cyc(1, 5'(i), ~fill_val(i), 0, 0, 5'(30 - i), 5'(i));
    for (int i = 0; i < 32; i++) cyc(0, 0, '0, 0, 0, 5'(31 - i), 5'(i));
    cyc(0, 0, '0, 0, 0, 31, 17);
    chk("sweep_inv_x17", rd_data2, ~64'hC0DE_0011_0000_0034);

    // Fill every register and every pend bit (write+issue same index)
    for (int i = 0; i < 31; i++) cyc(1, 5'(i), fill_val(i) ^ 64'h5A5A, 1, 5'(i), 5'(i), 31);
    cyc(0, 0, '0, 0, 0, 5, 9);
    chk("full_busy1", {63'd0, busy1}, 64'd1);
    chk("full_busy2", {63'd0, busy2}, 64'd1);

    // Assert reset between edges
    @(negedge clk);
    #1 reset_n = 0;
    #1;
    chk("midrst_rd_data1", rd_data1, '0);
    chk("midrst_rd_data2", rd_data2, '0);
    chk("midrst_busy1", {63'd0, busy1}, '0);
    chk("midrst_busy2", {63'd0, busy2}, '0);
    for (int i = 0; i < 32; i++) cyc(0, 0, '0, 1, 5'(i), 5'(i), 5'(31 - i));
    // Bypass stays live in reset, but the write is ignored
    cyc(1, 4, 64'hDEAD_BEEF_0000_0004, 1, 4, 4, 31);
    chk("rst_bypass", rd_data1, 64'hDEAD_BEEF_0000_0004);
    chk("rst_bypass_busy", {63'd0, busy1}, '0);
    @(negedge clk);
    wr_en = 0; iss_en = 0;
    reset_n = 1;
    cyc(0, 0, '0, 0, 0, 4, 5);
    chk("post_rst_x4", rd_data1, '0);
    chk("post_rst_busy4", {63'd0, busy1}, '0);
    chk("post_rst_x5", rd_data2, '0);

    // First edge after reset updates normally
    cyc(1, 4, 64'h4444, 1, 6, 31, 31);
    cyc(0, 0, '0, 0, 0, 4, 6);
    chk("post_rst_write", rd_data1, 64'h4444);
    chk("post_rst_issue", {63'd0, busy2}, 64'd1);

    @(negedge clk);
    check_en = 0;
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
